// File: rtl/mult_div_unit.sv
// Multi-cycle HI/LO multiply/divide unit. Operands are captured at the start edge and the
// combinational result is committed to HI/LO on the edge where the down-counter hits zero.
module mult_div_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic [2:0]  Op,
  input  logic        Start,
  output logic        Busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned CntMax = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES);
  localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES);

  localparam logic [2:0] OpMult  = 3'd1;
  localparam logic [2:0] OpMultu = 3'd2;
  localparam logic [2:0] OpDiv   = 3'd3;
  localparam logic [2:0] OpDivu  = 3'd4;
  localparam logic [2:0] OpMthi  = 3'd5;
  localparam logic [2:0] OpMtlo  = 3'd6;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      op_q, op_d;
  logic [31:0]     a_q, a_d, b_q, b_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;

  // One multiplier: low 64 bits of the product of the extended operands are exact for both
  // signednesses.
  logic        mul_signed;
  logic [63:0] mul_a, mul_b, prod;

  assign mul_signed = (op_q == OpMult);
  assign mul_a = {{32{mul_signed & a_q[31]}}, a_q};
  assign mul_b = {{32{mul_signed & b_q[31]}}, b_q};
  assign prod  = mul_a * mul_b;

  // One unsigned divider on magnitudes; signs restored afterwards. 0x80000000 / -1 falls out
  // naturally as quotient 0x80000000, remainder 0.
  logic        a_neg, b_neg;
  logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;

  assign a_neg = (op_q == OpDiv) & a_q[31];
  assign b_neg = (op_q == OpDiv) & b_q[31];
  assign a_mag = a_neg ? -a_q : a_q;
  assign b_mag = b_neg ? -b_q : b_q;
  assign q_mag = (b_mag == '0) ? '0 : a_mag / b_mag;
  assign r_mag = (b_mag == '0) ? '0 : a_mag % b_mag;
  assign quot  = (a_neg ^ b_neg) ? -q_mag : q_mag;
  assign rem   = a_neg ? -r_mag : r_mag;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    unique case (state_q)
      StIdle: begin
        if (Start) begin
          case (Op)
            OpMult, OpMultu: begin
              op_d    = Op;
              a_d     = A;
              b_d     = B;
              cnt_d   = MultLoad;
              state_d = StRun;
            end
            OpDiv, OpDivu: begin
              op_d    = Op;
              a_d     = A;
              b_d     = B;
              cnt_d   = DivLoad;
              state_d = StRun;
            end
            OpMthi:  hi_d = A;
            OpMtlo:  lo_d = A;
            default: ;
          endcase
        end
      end
      StRun: begin
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StIdle;
          if (op_q == OpMult || op_q == OpMultu) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
          end else if (b_q != '0) begin
            hi_d = rem;
            lo_d = quot;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  assign Busy = (state_q == StRun);
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Scoreboard bench for mult_div_unit: expected HI/LO and busy length are queued at issue and
// popped when Busy drops.
module tb_mult_div_unit;

  localparam int unsigned MultCycles = 5;
  localparam int unsigned DivCycles  = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] A, B;
  logic [2:0]  Op;
  logic        Start;
  logic        Busy;
  logic [31:0] HI, LO;

  mult_div_unit #(
    .MULT_CYCLES(MultCycles),
    .DIV_CYCLES (DivCycles)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .A    (A),
    .B    (B),
    .Op   (Op),
    .Start(Start),
    .Busy (Busy),
    .HI   (HI),
    .LO   (LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int          cycles;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model_hi = '0;
  logic [31:0] model_lo = '0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference model written from the arithmetic definitions, independent of the RTL datapath.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo);
    longint      ps;
    logic [63:0] pu;
    int          sa, sb_v;
    hi = model_hi;
    lo = model_lo;
    sa   = a;
    sb_v = b;
    case (op)
      3'd1: begin
        ps = longint'(sa) * longint'(sb_v);
        {hi, lo} = ps;
      end
      3'd2: begin
        pu = {32'd0, a} * {32'd0, b};
        {hi, lo} = pu;
      end
      3'd3: begin
        if (b != 0) begin
          if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            lo = 32'h8000_0000;
            hi = 32'd0;
          end else begin
            lo = sa / sb_v;
            hi = sa % sb_v;
          end
        end
      end
      3'd4: begin
        if (b != 0) begin
          lo = a / b;
          hi = a % b;
        end
      end
      default: ;
    endcase
  endtask

  // Issues a long op; dist_at >= 0 pulses Start with an mtlo and junk A at that busy cycle.
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int dist_at);
    exp_t e;
    exp_t got_e;
    int   n;
    model(op, a, b, e.hi, e.lo);
    e.cycles = (op == 3'd1 || op == 3'd2) ? MultCycles : DivCycles;
    sb.push_back(e);
    @(negedge clk);
    A = a; B = b; Op = op; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; Op = 3'd0;
    n = 0;
    while (Busy && n < 200) begin
      check_eq("hold_hi", {32'd0, HI}, {32'd0, model_hi});
      check_eq("hold_lo", {32'd0, LO}, {32'd0, model_lo});
      if (n == dist_at) begin
        A = 32'hDEAD_BEEF; B = 32'h1; Op = 3'd6; Start = 1'b1;
      end else begin
        Start = 1'b0; Op = 3'd0;
      end
      n++;
      @(negedge clk);
    end
    Start = 1'b0; Op = 3'd0;
    got_e = sb.pop_front();
    check_eq("busy_len", 64'(n), 64'(got_e.cycles));
    check_eq("res_hi", {32'd0, HI}, {32'd0, got_e.hi});
    check_eq("res_lo", {32'd0, LO}, {32'd0, got_e.lo});
    model_hi = got_e.hi;
    model_lo = got_e.lo;
  endtask

  task automatic move(input logic [2:0] op, input logic [31:0] a);
    exp_t e;
    e.hi = model_hi;
    e.lo = model_lo;
    e.cycles = 0;
    if (op == 3'd5) e.hi = a;
    if (op == 3'd6) e.lo = a;
    sb.push_back(e);
    @(negedge clk);
    A = a; Op = op; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; Op = 3'd0;
    e = sb.pop_front();
    check_eq("mv_busy", {63'd0, Busy}, 64'd0);
    check_eq("mv_hi", {32'd0, HI}, {32'd0, e.hi});
    check_eq("mv_lo", {32'd0, LO}, {32'd0, e.lo});
    model_hi = e.hi;
    model_lo = e.lo;
  endtask

  initial begin
    // Reset with a simultaneous mthi request: reset must win.
    reset = 1'b0; A = 32'hFFFF_FFFF; B = '0; Op = 3'd5; Start = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_busy", {63'd0, Busy}, 64'd0);
    check_eq("rst_hi", {32'd0, HI}, 64'd0);
    check_eq("rst_lo", {32'd0, LO}, 64'd0);
    reset = 1'b1; Start = 1'b0; Op = 3'd0;

    run_op(3'd1, 32'hFFFF_FFFE, 32'd3, -1);
    run_op(3'd2, 32'hFFFF_FFFF, 32'd2, -1);
    run_op(3'd3, 32'hFFFF_FFF9, 32'd2, -1);
    run_op(3'd4, 32'd7, 32'd2, -1);
    run_op(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, -1);
    run_op(3'd3, 32'd7, 32'hFFFF_FFFE, -1);
    move(3'd6, 32'h1234_5678);
    run_op(3'd4, 32'd99, 32'd0, -1);
    move(3'd5, 32'hCAFE_0001);
    run_op(3'd3, 32'hFFFF_FF00, 32'd0, -1);

    // Op 7 and Op 0 do nothing.
    move(3'd7, 32'h5555_5555);
    move(3'd0, 32'h6666_6666);

    // Operand change plus mtlo mid-run, and a Start on the completing edge.
    run_op(3'd1, 32'd1000, 32'hFFFF_FFF0, 2);
    run_op(3'd2, 32'h0001_0000, 32'h0003_0000, MultCycles - 1);
    run_op(3'd4, 32'hFFFF_FFF0, 32'd3, DivCycles - 1);

    for (int i = 0; i < 8; i++) begin
      run_op(3'($urandom_range(1, 4)), $urandom, (i == 3) ? 32'd0 : $urandom, -1);
    end

    // Abort a divide with reset partway through.
    @(negedge clk);
    A = 32'd100; B = 32'd7; Op = 3'd3; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0; Op = 3'd0;
    check_eq("abort_busy_pre", {63'd0, Busy}, 64'd1);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    check_eq("abort_busy", {63'd0, Busy}, 64'd0);
    check_eq("abort_hi", {32'd0, HI}, 64'd0);
    check_eq("abort_lo", {32'd0, LO}, 64'd0);
    model_hi = '0;
    model_lo = '0;
    repeat (DivCycles) @(negedge clk);
    check_eq("abort_hold_lo", {32'd0, LO}, 64'd0);
    run_op(3'd1, 32'd12345, 32'd678, -1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, meaning Busy duration of mult/multu in cycles.
REQ-002 SHALL have parameter DIV_CYCLES, default 10, meaning Busy duration of div/divu in cycles.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-005 SHALL have port A  input  32  operand rs (dividend / multiplicand / mthi-mtlo data).
REQ-006 SHALL have port B  input  32  operand rt (divisor / multiplier).
REQ-007 SHALL have port Op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
REQ-008 SHALL have port Start  input  1  one-cycle pulse from EX stage qualifying Op as a new operation.
REQ-009 SHALL have port Busy  output  1  operation in progress; consumed by the pipeline stall logic together with Start.
REQ-010 SHALL have port HI  output  32  architectural HI register.
REQ-011 SHALL have port LO  output  32  architectural LO register.

Function
REQ-012 SHALL implement two states: IDLE (Busy=0) and RUN (Busy=1), with a down-counter cnt sized to hold DIV_CYCLES.
REQ-013 IDLE, on an edge with Start=1 and Op in {1,2}: SHALL capture operands, load cnt=MULT_CYCLES, and enter RUN.
REQ-014 IDLE, on an edge with Start=1 and Op in {3,4}: SHALL capture operands, load cnt=DIV_CYCLES, and enter RUN.
REQ-015 IDLE, on an edge with Start=1 and Op=5/6: SHALL write A into HI/LO at that edge; Busy stays 0; no RUN entry.
REQ-016 Start=1 with Op in {0,7} SHALL have no effect.
REQ-017 RUN: cnt SHALL decrement each edge; Busy SHALL be high for exactly N cycles following the start edge (N=MULT_CYCLES or DIV_CYCLES).
REQ-018 HI/LO SHALL update only at the edge where cnt goes 1->0; that same edge SHALL return the unit to IDLE.
REQ-019 HI/LO SHALL hold previous values throughout RUN; the new result SHALL become visible in the cycle Busy first reads 0.
REQ-020 mult: SHALL set {HI,LO} = signed(A)*signed(B), a 64-bit two's-complement product.
REQ-021 multu: SHALL set {HI,LO} = unsigned(A)*unsigned(B), a 64-bit product.
REQ-022 div: SHALL set LO to the signed quotient truncated toward zero and HI to the remainder, which takes the dividend's sign.
REQ-023 div of 0x80000000 by -1: SHALL give LO=0x80000000, HI=0.
REQ-024 divu: SHALL set LO=A/B and HI=A%B, both unsigned.
REQ-025 Divisor 0 (div/divu): SHALL run the full DIV_CYCLES with Busy asserted, then leave HI/LO unchanged.
REQ-026 Start while in RUN (any Op): SHALL be ignored, with no restart, operand capture, or HI/LO write; the stall logic guarantees this does not occur legally.
REQ-027 Operands SHALL be captured at the start edge; later changes on A/B SHALL NOT affect the result.
REQ-028 At the completing edge, a simultaneous Start SHALL be ignored; a new operation SHALL be accepted only in IDLE.
REQ-029 Arithmetic SHALL be combinational on captured operands, registered at completion; cnt is timing-only.

Reset
REQ-030 reset=0 at a rising edge SHALL force IDLE, cnt=0, Busy=0, HI=0, LO=0 and clear the captured operands.
REQ-031 Reset during RUN SHALL abort the operation with no HI/LO write; Busy SHALL read 0 in the cycle after the reset edge.
REQ-032 reset SHALL take priority over Start at the same edge.

Verification
REQ-033 mult, A=0xFFFFFFFE (-2), B=3 -> Busy high 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; HI/LO at the old values while Busy=1.
REQ-034 multu, A=0xFFFFFFFF, B=2 -> after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
REQ-035 div, A=0xFFFFFFF9 (-7), B=2 -> Busy high 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu A=7, B=2 -> LO=3, HI=1.
REQ-036 mtlo A=0x12345678 then divu with B=0 -> Busy 10 cycles, then LO=0x12345678 and HI unchanged.
REQ-037 mult started, A changed and Start with Op=6 pulsed at cycle 2 -> result from the original operands; LO not overwritten by the mtlo.
REQ-038 div started, reset=0 at cycle 4 -> Busy=0 and HI=LO=0 next cycle; a subsequent mult completes normally in 5 cycles.
